pingpang_packer: RTL and testbench
==================================

// Module: pingpang_packer
// PURPOSE
//   Upstream feeder for the 128-bit ping-pong serial stage. Packs a stream of
//   32-bit beats into 128-bit words over a valid/ready handshake.
//   Uses two 128-bit banks (ping/pong), so one bank fills while the other drains.
//   Downstream sees one complete 128-bit word per out_valid/out_ready transfer.
// PARAMETERS
//   DW      32  input beat width in bits
//   NBEATS  4   beats per output word; out_data width = DW*NBEATS (128)
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous reset, active-high
//   in_valid   in   1       in_data is valid
//   in_ready   out  1       packer can accept a beat
//   in_data    in   DW      input beat
//   in_last    in   1       [PACK_FLUSH_EN only] close the word after this beat
//   out_valid  out  1       out_data holds a complete word
//   out_ready  in   1       downstream accepts the word
//   out_data   out  DW*NB   packed word; beat 0 in bits [DW-1:0]
//   out_keep   out  NBEATS  lane-valid mask; bit i = lane i holds real data
// BEHAVIOUR
//   - Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
//   - Reset: both bank full flags = 0, wr_bank = rd_bank = 0, lane_cnt = 0.
//     Output reset values: out_data = 0, out_keep = 0, out_valid = 0.
//     in_ready is forced to 0 while rst is high.
//   - Input accept: a beat is accepted when in_valid && in_ready.
//     in_ready = !full[wr_bank] && !rst.
//   - On accept: bank[wr_bank][lane_cnt*DW +: DW] <= in_data; lane_cnt increments.
//   - Close on the beat where lane_cnt == NBEATS-1:
//     full[wr_bank] <= 1, wr_bank toggles, lane_cnt <= 0.
//   - Output: out_valid = full[rd_bank]; out_data and out_keep come from bank rd_bank.
//     Bank registers are the outputs; no extra pipeline stage.
//   - Drain: on out_valid && out_ready, full[rd_bank] <= 0 and rd_bank toggles.
//   - Latency: out_valid rises the cycle after the closing beat is accepted.
//   - Throughput: sustains 1 beat/cycle if out_ready is high at least once
//     every NBEATS cycles.
//   - Both banks full: in_ready = 0; in_data is held by the upstream source.
//     Nothing is dropped or overwritten.
//   - Fill and drain in the same cycle: allowed. They always target different
//     banks; the set and the clear apply independently.
//   - Drain frees the write bank: in_ready rises the cycle after the drain.
//   - Stability: out_data/out_keep do not change while out_valid && !out_ready.
//   - Unwritten lanes of a bank are cleared to 0 when the bank is drained.
//   - Reset mid-word: the partial word is discarded, all state returns to reset values.
//     The first beat after reset goes into lane 0 of bank 0.
// CONFIGURATION
//   PACK_FLUSH_EN defined:
//     - in_last is present. An accepted beat with in_last = 1 closes the word
//       immediately: full set, wr_bank toggles, lane_cnt = 0.
//     - Lanes above the last written lane read 0.
//     - out_keep = mask of written lanes, e.g. 2 beats -> 4'b0011.
//     - in_last on the NBEATS-th beat behaves as a normal close.
//   PACK_FLUSH_EN undefined:
//     - in_last port is absent; words close only after NBEATS beats.
//     - out_keep is {NBEATS{1'b1}} whenever out_valid = 1.
// TESTING
//   1. Reset: rst=1 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_data=0;
//      after release -> in_ready=1.
//   2. Single word, out_ready=1, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444
//      -> next cycle out_valid=1, out_data=0x44444444_33333333_22222222_11111111,
//      out_keep=4'hF.
//   3. Backpressure: out_ready=0, push 9 beats -> in_ready=0 after beat 8, beat 9 held;
//      raise out_ready -> words 1 and 2 drain in order; in_ready=1 the cycle after the
//      first drain; beat 9 lands in lane 0.
//   4. Streaming: 16 back-to-back beats 0..15, out_ready=1 -> 4 words, in_ready never 0,
//      word k lanes = {4k+3, 4k+2, 4k+1, 4k}.
//   5. Reset mid-word: 2 beats, pulse rst, then beats A,B,C,D
//      -> single word {D,C,B,A} from bank 0; no residue from the pre-reset beats.
//   6. [PACK_FLUSH_EN] beats 0xAAAA0001, 0xAAAA0002 with in_last on the 2nd
//      -> out_data[127:64]=0, out_data[63:0]=0xAAAA0002_AAAA0001, out_keep=4'b0011;
//      the next beat goes into lane 0 of the other bank.

Source files
------------

// File: rtl/pingpang_packer_if.sv
// rtl/pingpang_packer_if.sv - beat-in / word-out handshake bundle for pingpang_packer
// Ports (signals):
//   in_valid, in_ready, in_data[DW-1:0], in_last (PACK_FLUSH_EN only)
//   out_valid, out_ready, out_data[DW*NBEATS-1:0], out_keep[NBEATS-1:0]
// Modports: master = beat source / word sink, slave = the packer.
// Optional feature macro: PACK_FLUSH_EN (adds in_last).
interface pingpang_packer_if #(
  parameter int DW     = 32,
  parameter int NBEATS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
`ifdef PACK_FLUSH_EN
  logic                 in_last;
`endif
  logic                 out_valid;
  logic                 out_ready;
  logic [DW*NBEATS-1:0] out_data;
  logic [NBEATS-1:0]    out_keep;

  modport master (
`ifdef PACK_FLUSH_EN
    output in_last,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_keep
  );

  modport slave (
`ifdef PACK_FLUSH_EN
    input  in_last,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_keep
  );
endinterface

// File: rtl/pingpang_packer.sv
// rtl/pingpang_packer.sv - packs DW-bit beats into DW*NBEATS-bit words through two ping/pong banks
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous reset, active-high
//   bus  pingpang_packer_if.slave (in_valid/in_ready/in_data[/in_last], out_valid/out_ready/out_data/out_keep)
// Optional feature macro: PACK_FLUSH_EN (in_last closes a short word; out_keep marks written lanes).
module pingpang_packer #(
  parameter int DW     = 32,
  parameter int NBEATS = 4
) (
  input  logic             clk,
  input  logic             rst,
  pingpang_packer_if.slave bus
);
  localparam int            LW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(NBEATS - 1);

  logic [DW*NBEATS-1:0] bank [2];
  logic [1:0]           full;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [LW-1:0]        lane_cnt;
  logic                 accept;
  logic                 drain;
  logic                 close;

  // A bank is only written while not full and only drained while full,
  // so a fill and a drain in the same cycle never touch the same bank.
  assign bus.in_ready  = !full[wr_bank] && !rst;
  assign bus.out_valid = full[rd_bank];
  assign bus.out_data  = bank[rd_bank];

  assign accept = bus.in_valid && bus.in_ready;
  assign drain  = bus.out_valid && bus.out_ready;

`ifdef PACK_FLUSH_EN
  logic [NBEATS-1:0] keep [2];

  assign close        = accept && ((lane_cnt == LAST_LANE) || bus.in_last);
  assign bus.out_keep = keep[rd_bank];
`else
  assign close        = accept && (lane_cnt == LAST_LANE);
  assign bus.out_keep = {NBEATS{full[rd_bank]}};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bank[0]  <= '0;
      bank[1]  <= '0;
      full     <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      lane_cnt <= '0;
`ifdef PACK_FLUSH_EN
      keep[0]  <= '0;
      keep[1]  <= '0;
`endif
    end else begin
      if (drain) begin
        // Clearing on drain keeps lanes a short word never wrote at zero.
        bank[rd_bank] <= '0;
        full[rd_bank] <= 1'b0;
        rd_bank       <= !rd_bank;
`ifdef PACK_FLUSH_EN
        keep[rd_bank] <= '0;
`endif
      end
      if (accept) begin
        bank[wr_bank][lane_cnt*DW +: DW] <= bus.in_data;
`ifdef PACK_FLUSH_EN
        keep[wr_bank][lane_cnt] <= 1'b1;
`endif
        if (close) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          lane_cnt      <= '0;
        end else begin
          lane_cnt <= lane_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pingpang_packer.sv
// tb/tb_pingpang_packer.sv - self-checking bench for pingpang_packer (table vectors, directed sequences, random vs queue model)
module tb_pingpang_packer;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int WW = DW * NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pingpang_packer_if #(.DW(DW), .NBEATS(NB)) bus ();
  pingpang_packer #(.DW(DW), .NBEATS(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [WW-1:0] data;
    logic [NB-1:0] keep;
  } word_t;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          e_rdy;
    logic          e_vld;
    logic [WW-1:0] e_data;
    logic [NB-1:0] e_keep;
  } vec_t;

  // Reference model: words closed but not yet taken, plus the word being built.
  word_t         exp_q[$];
  logic [WW-1:0] cur_data = '0;
  logic [NB-1:0] cur_keep = '0;
  int            cur_n    = 0;
  logic          last_acc = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic lst);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
`ifdef PACK_FLUSH_EN
    bus.in_last   = lst;
`else
    if (lst) begin end
`endif
  endtask

  // Called at a negedge with inputs already applied: compare against the
  // model, cross the posedge, advance the model, leave time at posedge+1.
  task automatic tick();
    logic exp_rdy, exp_vld, acc, drn, flush;
    exp_rdy = (rst == 1'b0) && (exp_q.size() < 2);
    exp_vld = exp_q.size() > 0;
    check("in_ready", WW'(bus.in_ready), WW'(exp_rdy));
    check("out_valid", WW'(bus.out_valid), WW'(exp_vld));
    if (exp_vld) begin
      check("out_data", bus.out_data, exp_q[0].data);
      check("out_keep", WW'(bus.out_keep), WW'(exp_q[0].keep));
    end
    acc = bus.in_valid && exp_rdy;
    drn = bus.out_ready && exp_vld;
`ifdef PACK_FLUSH_EN
    flush = bus.in_last;
`else
    flush = 1'b0;
`endif
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      cur_n    = 0;
      cur_data = '0;
      cur_keep = '0;
      acc      = 1'b0;
    end else begin
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
        cur_data[cur_n*DW +: DW] = bus.in_data;
        cur_keep[cur_n]          = 1'b1;
        cur_n++;
        if (cur_n == NB || flush) begin
          exp_q.push_back('{data: cur_data, keep: cur_keep});
          cur_n    = 0;
          cur_data = '0;
          cur_keep = '0;
        end
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    tick();
  endtask

  task automatic drain_all(input string name);
    set_in(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cyc();
    check(name, WW'(exp_q.size()), WW'(0));
  endtask

  vec_t          tbl[6];
  int            beat;
  int            stall;
  int            cycles;
  logic [WW-1:0] got;
  logic          pend;
  logic [DW-1:0] pdata;
  logic          plast;

  initial begin
    // Single word, beats 0x11.. to 0x44.., then an idle drain cycle.
    tbl[0] = '{1'b1, 32'h11111111, 1'b1, 1'b1, 1'b0, '0, '0};
    tbl[1] = '{1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0, '0, '0};
    tbl[2] = '{1'b1, 32'h33333333, 1'b1, 1'b1, 1'b0, '0, '0};
    tbl[3] = '{1'b1, 32'h44444444, 1'b1, 1'b1, 1'b0, '0, '0};
    tbl[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 128'h44444444_33333333_22222222_11111111, 4'hF};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b0, '0, '0};

    // Reset held with in_valid high.
    rst = 1'b1;
    set_in(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_out_data", bus.out_data, '0);
      check("rst_out_keep", WW'(bus.out_keep), '0);
      tick();
    end
    rst = 1'b0;
    set_in(1'b0, '0, 1'b0, 1'b0);
    cyc();

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].iv, tbl[i].d, tbl[i].ordy, 1'b0);
      @(negedge clk);
      check("tbl_in_ready", WW'(bus.in_ready), WW'(tbl[i].e_rdy));
      check("tbl_out_valid", WW'(bus.out_valid), WW'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        check("tbl_out_data", bus.out_data, tbl[i].e_data);
        check("tbl_out_keep", WW'(bus.out_keep), WW'(tbl[i].e_keep));
      end
      tick();
    end

    // Backpressure: 9 beats offered with out_ready low, only 8 fit.
    beat = 1;
    for (int i = 0; i < 12; i++) begin
      set_in(beat <= 9, DW'(beat), 1'b0, 1'b0);
      cyc();
      if (last_acc) beat++;
    end
    check("bp_accepted", WW'(beat - 1), WW'(8));
    for (int i = 0; i < 20 && (beat <= 12 || exp_q.size() > 0); i++) begin
      set_in(beat <= 12, DW'(beat), 1'b1, 1'b0);
      cyc();
      if (last_acc) beat++;
    end
    check("bp_done", WW'(exp_q.size() + cur_n), WW'(0));

    // Streaming 16 beats back to back.
    beat   = 0;
    stall  = 0;
    cycles = 0;
    for (int c = 0; c < 40 && beat < 16; c++) begin
      set_in(1'b1, DW'(beat), 1'b1, 1'b0);
      @(negedge clk);
      if (!bus.in_ready) stall++;
      tick();
      cycles++;
      if (last_acc) beat++;
    end
    check("stream_stalls", WW'(stall), WW'(0));
    check("stream_cycles", WW'(cycles), WW'(16));
    drain_all("stream_drain");

    // Reset in the middle of a word.
    set_in(1'b1, 32'h0BAD0000, 1'b0, 1'b0);
    cyc();
    set_in(1'b1, 32'h0BAD0001, 1'b0, 1'b0);
    cyc();
    rst = 1'b1;
    set_in(1'b0, '0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    beat = 0;
    got  = '0;
    for (int i = 0; i < 12 && (beat < 4 || exp_q.size() > 0); i++) begin
      set_in(beat < 4, 32'hA0A0A0A0 + DW'(beat), 1'b1, 1'b0);
      @(negedge clk);
      if (bus.out_valid) got = bus.out_data;
      tick();
      if (last_acc) beat++;
    end
    check("rst_mid_word", got, 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0);

`ifdef PACK_FLUSH_EN
    // Short word closed by in_last, then a beat into the other bank.
    set_in(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
    cyc();
    set_in(1'b1, 32'hAAAA0002, 1'b0, 1'b1);
    cyc();
    set_in(1'b1, 32'hBBBB0003, 1'b0, 1'b1);
    @(negedge clk);
    check("flush_data", bus.out_data, 128'h0_0_AAAA0002_AAAA0001);
    check("flush_keep", WW'(bus.out_keep), WW'(4'b0011));
    tick();
    drain_all("flush_drain");
`endif

    // Randomized traffic against the queue model; a presented beat is held
    // until accepted, with occasional resets.
    pend = 1'b0;
    pdata = '0;
    plast = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend) begin
        pend  = ($urandom % 4) != 0;
        pdata = $urandom;
        plast = ($urandom % 6) == 0;
      end
      rst = ($urandom % 500) == 0;
      set_in(pend, pdata, ($urandom % 2) == 0, plast);
      cyc();
      if (last_acc) pend = 1'b0;
    end
    rst = 1'b0;
    drain_all("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
